data_path_p: RTL and testbench

Parametrised next-generation CPU datapath: program counter, multi-register file, operand mux and ALU with status flags. An internal sequencer replaces the external enable-pulse chain. Each instruction launched by a one-cycle start runs through a fixed READ/EXEC/WB sequence, and completion is reported with a done pulse. The block sits under the control unit, which supplies decoded fields and waits on busy/done.

---
 rtl/data_path_p.sv | 184 ++++++++++++++++++
 tb/tb_data_path_p.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_path_p.sv
// data_path_p: PC, register file, operand mux and ALU with {Z,N,C,V} flags, sequenced by an
// internal IDLE->READ->EXEC->WB FSM. Latency: done pulses in WB, 3 cycles after the start edge;
// one instruction every 4 cycles. Backpressure: start is ignored while busy (no queueing).
// Ports: clk, rst (async active-low); start + decoded fields in; busy, done, pc_out, alu_out, flags out.
// Optional macro ZERO_REG_EN: reg[0] reads as 0 and writes to it are dropped.
module data_path_p #(
  parameter int DW   = 16,
  parameter int AW   = 2,
  parameter int OFFW = 8,
  parameter int PCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      pc_ctrl,
  input  logic [OFFW-1:0] offset_addr,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rs,
  input  logic [OFFW-1:0] imm,
  input  logic            alu_in_sel,
  input  logic [3:0]      alu_func,
  input  logic            wb_en,
  output logic            busy,
  output logic            done,
  output logic [PCW-1:0]  pc_out,
  output logic [DW-1:0]   alu_out,
  output logic [3:0]      flags
);

  localparam int NREG = 2 ** AW;
  localparam logic [DW-1:0] DW_V = DW[DW-1:0];

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_nxt;

  // instruction fields held for the whole READ/EXEC/WB sequence
  logic [1:0]      pc_ctrl_q;
  logic [OFFW-1:0] offset_q;
  logic [AW-1:0]   rd_q, rs_q;
  logic [OFFW-1:0] imm_q;
  logic            sel_q;
  logic [3:0]      func_q;
  logic            wb_en_q;

  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   a_q, b_q;
  logic [DW-1:0]   a_rd, b_rd, b_mux;
  logic            wr_ok;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == WB);
  end

  // ---------------- register read / operand mux ----------------
`ifdef ZERO_REG_EN
  assign a_rd  = (rd_q == '0) ? '0 : regs[rd_q];
  assign b_rd  = (rs_q == '0) ? '0 : regs[rs_q];
  assign wr_ok = wb_en_q && (rd_q != '0);
`else
  assign a_rd  = regs[rd_q];
  assign b_rd  = regs[rs_q];
  assign wr_ok = wb_en_q;
`endif

  assign b_mux = sel_q ? {{(DW-OFFW){imm_q[OFFW-1]}}, imm_q} : b_rd;

  // ---------------- ALU ----------------
  logic [DW-1:0] res;
  logic [DW:0]   sum_ext;
  logic [DW-1:0] shamt;
  logic          c_f, v_f;

  always_comb begin
    res     = '0;
    c_f     = 1'b0;
    v_f     = 1'b0;
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    shamt   = b_q % DW_V;
    case (func_q)
      4'h0: begin
        res = sum_ext[DW-1:0];
        c_f = sum_ext[DW];
        v_f = (a_q[DW-1] == b_q[DW-1]) && (res[DW-1] != a_q[DW-1]);
      end
      4'h1: begin
        res = a_q - b_q;
        c_f = (a_q < b_q);
        v_f = (a_q[DW-1] != b_q[DW-1]) && (res[DW-1] != a_q[DW-1]);
      end
      4'h2: res = a_q & b_q;
      4'h3: res = a_q | b_q;
      4'h4: res = a_q ^ b_q;
      4'h5: res = ~a_q;
      4'h6: res = a_q << shamt;
      4'h7: res = a_q >> shamt;
      4'h8: res = $unsigned($signed(a_q) >>> shamt);
      4'h9: res = b_q;
      4'hA: res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: res = '0;
    endcase
  end

  // ---------------- PC next value ----------------
  // branch uses Z latched in EXEC, i.e. the result of this same instruction
  logic [PCW-1:0] pc_inc, pc_nxt;
  assign pc_inc = pc_out + PCW'(1);

  always_comb begin
    pc_nxt = pc_out;
    case (pc_ctrl_q)
      2'b00: pc_nxt = pc_out;
      2'b01: pc_nxt = pc_inc;
      2'b10: pc_nxt = {{(PCW-OFFW){1'b0}}, offset_q};
      2'b11: pc_nxt = flags[3] ? (pc_out + {{(PCW-OFFW){offset_q[OFFW-1]}}, offset_q}) : pc_inc;
      default: pc_nxt = pc_out;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_ctrl_q <= '0;
      offset_q  <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      sel_q     <= 1'b0;
      func_q    <= '0;
      wb_en_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      flags     <= '0;
      pc_out    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc_ctrl_q <= pc_ctrl;
          offset_q  <= offset_addr;
          rd_q      <= rd;
          rs_q      <= rs;
          imm_q     <= imm;
          sel_q     <= alu_in_sel;
          func_q    <= alu_func;
          wb_en_q   <= wb_en;
        end
        READ: begin
          a_q <= a_rd;
          b_q <= b_mux;
        end
        EXEC: begin
          alu_out <= res;
          flags   <= {(res == '0), res[DW-1], c_f, v_f};
        end
        WB: begin
          if (wr_ok) regs[rd_q] <= alu_out;
          pc_out <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_path_p.sv
// Bench for data_path_p: directed instructions with hand-computed results pushed to a
// scoreboard queue; a monitor pops on each done pulse and checks alu_out/flags, then pc.
module tb_data_path_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;
  logic [1:0]  rd, rs;
  logic [7:0]  imm;
  logic        alu_in_sel;
  logic [3:0]  alu_func;
  logic        wb_en;
  logic        busy, done;
  logic [15:0] pc_out, alu_out;
  logic [3:0]  flags;

  data_path_p dut (
    .clk(clk), .rst(rst), .start(start), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .rd(rd), .rs(rs), .imm(imm), .alu_in_sel(alu_in_sel), .alu_func(alu_func), .wb_en(wb_en),
    .busy(busy), .done(done), .pc_out(pc_out), .alu_out(alu_out), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [3:0]  flg;
    logic [15:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("alu_out", alu_out, e.alu);
          chk("flags", flags, e.flg);
          @(posedge clk);
          #1;
          chk("pc_out", pc_out, e.pc);
        end
      end
    end
  end

  task automatic scramble();
    pc_ctrl     = 2'($urandom);
    offset_addr = 8'($urandom);
    rd          = 2'($urandom);
    rs          = 2'($urandom);
    imm         = 8'($urandom);
    alu_in_sel  = 1'($urandom);
    alu_func    = 4'($urandom);
    wb_en       = 1'($urandom);
  endtask

  task automatic drive(input logic [1:0] pc_i, input logic [7:0] off_i, input logic [1:0] rd_i,
                       input logic [1:0] rs_i, input logic [7:0] imm_i, input logic sel_i,
                       input logic [3:0] fn_i, input logic wb_i);
    pc_ctrl = pc_i; offset_addr = off_i; rd = rd_i; rs = rs_i; imm = imm_i;
    alu_in_sel = sel_i; alu_func = fn_i; wb_en = wb_i;
  endtask

  // issue one instruction, check done latency, return just after E3
  task automatic issue(input logic [1:0] pc_i, input logic [7:0] off_i, input logic [1:0] rd_i,
                       input logic [1:0] rs_i, input logic [7:0] imm_i, input logic sel_i,
                       input logic [3:0] fn_i, input logic wb_i,
                       input logic [15:0] ea, input logic [3:0] ef, input logic [15:0] ep);
    int lat;
    @(negedge clk);
    drive(pc_i, off_i, rd_i, rs_i, imm_i, sel_i, fn_i, wb_i);
    start = 1'b1;
    sb_q.push_back('{ea, ef, ep});
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat > 10) break;
    end
    chk("done_latency", lat, 3);
    @(posedge clk);
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b0;
    start = 1'b0;
    drive(2'b00, 8'h00, 2'd0, 2'd0, 8'h00, 1'b0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_out, 0);
    chk("rst_alu", alu_out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    //     pc    off    rd  rs  imm    sel fn    wb    alu      flg     pc
    issue(2'b01, 8'h00, 1, 1, 8'h05, 1, 4'h0, 1, 16'h0005, 4'b0000, 16'h0001); // ADD reg1=5
    issue(2'b00, 8'h00, 2, 1, 8'h00, 0, 4'h9, 0, 16'h0005, 4'b0000, 16'h0001); // MOV reg1
    issue(2'b01, 8'h00, 1, 0, 8'hFF, 1, 4'h9, 1, 16'hFFFF, 4'b0100, 16'h0002); // reg1=FFFF
    issue(2'b01, 8'h00, 1, 0, 8'h01, 1, 4'h7, 1, 16'h7FFF, 4'b0000, 16'h0003); // SHR
    issue(2'b01, 8'h00, 1, 0, 8'h01, 1, 4'h0, 1, 16'h8000, 4'b0101, 16'h0004); // ADD ovf
    issue(2'b01, 8'h00, 1, 0, 8'h01, 1, 4'h9, 1, 16'h0001, 4'b0000, 16'h0005); // reg1=1
    issue(2'b01, 8'h00, 2, 0, 8'h02, 1, 4'h9, 1, 16'h0002, 4'b0000, 16'h0006); // reg2=2
    issue(2'b01, 8'h00, 1, 2, 8'h00, 0, 4'h1, 0, 16'hFFFF, 4'b0110, 16'h0007); // SUB borrow
    issue(2'b10, 8'h0A, 3, 3, 8'h00, 0, 4'h2, 0, 16'h0000, 4'b1000, 16'h000A); // jump 10
    issue(2'b11, 8'hFE, 1, 1, 8'h00, 0, 4'h1, 0, 16'h0000, 4'b1000, 16'h0008); // branch taken
    issue(2'b10, 8'h0A, 3, 3, 8'h00, 0, 4'h4, 0, 16'h0000, 4'b1000, 16'h000A); // jump 10
    issue(2'b11, 8'hFE, 1, 2, 8'h00, 0, 4'h1, 0, 16'hFFFF, 4'b0110, 16'h000B); // not taken
    issue(2'b11, 8'hF5, 3, 3, 8'h00, 0, 4'h3, 0, 16'h0000, 4'b1000, 16'h0000); // to 0
    issue(2'b11, 8'hFF, 3, 3, 8'h00, 0, 4'h2, 0, 16'h0000, 4'b1000, 16'hFFFF); // to FFFF
    issue(2'b01, 8'h00, 3, 0, 8'h00, 0, 4'h5, 0, 16'hFFFF, 4'b0100, 16'h0000); // NOT, pc wrap
    issue(2'b01, 8'h00, 3, 0, 8'h80, 1, 4'h9, 1, 16'hFF80, 4'b0100, 16'h0001); // reg3=FF80
    issue(2'b01, 8'h00, 3, 0, 8'h04, 1, 4'h8, 0, 16'hFFF8, 4'b0100, 16'h0002); // SRA
    issue(2'b01, 8'h00, 2, 0, 8'h13, 1, 4'h6, 0, 16'h0010, 4'b0000, 16'h0003); // SHL mod 16
    issue(2'b00, 8'h00, 3, 2, 8'h00, 0, 4'hA, 0, 16'h0001, 4'b0000, 16'h0003); // SLT
    issue(2'b00, 8'h00, 3, 0, 8'h80, 1, 4'h0, 0, 16'hFF00, 4'b0110, 16'h0003); // ADD carry
    issue(2'b01, 8'h00, 1, 1, 8'h00, 0, 4'hB, 0, 16'h0000, 4'b1000, 16'h0004); // func B

    // start held for 8 edges: captures only at E0 and E4
    @(negedge clk);
    sb_q.push_back('{16'h0003, 4'b0000, 16'h0005});
    sb_q.push_back('{16'h0004, 4'b0000, 16'h0006});
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0 || k == 4) drive(2'b01, 8'h00, 2, 0, 8'h01, 1, 4'h0, 1);
      else                  scramble();
      start = 1'b1;
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("busy_cycles", busy_cnt, 6);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    issue(2'b00, 8'h00, 0, 2, 8'h00, 0, 4'h9, 0, 16'h0004, 4'b0000, 16'h0006); // reg2=4

    // reset during EXEC of a write to reg2
    @(negedge clk);
    drive(2'b01, 8'h00, 2, 0, 8'h10, 1, 4'h9, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pc", pc_out, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    issue(2'b00, 8'h00, 0, 2, 8'h00, 0, 4'h9, 0, 16'h0000, 4'b1000, 16'h0000); // reg2=0

    issue(2'b01, 8'h00, 0, 0, 8'h07, 1, 4'h9, 1, 16'h0007, 4'b0000, 16'h0001); // reg0=7
`ifdef ZERO_REG_EN
    issue(2'b01, 8'h00, 0, 0, 8'h00, 1, 4'h0, 0, 16'h0000, 4'b1000, 16'h0002);
`else
    issue(2'b01, 8'h00, 0, 0, 8'h00, 1, 4'h0, 0, 16'h0007, 4'b0000, 16'h0002);
`endif

    repeat (3) @(negedge clk);
    chk("sb_final", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
